nx_accum_drain: RTL and testbench

Downstream stage of the signed product cores. It accumulates a stream of full-width signed products into per-vector sums, delimited by a last flag. Each finished sum is scaled by an arithmetic right shift and saturated to the output width. Results are queued in a small output FIFO with valid/ready handshake toward the consumer (vector register file / activation stage). The product cores cannot stall, so there is no input ready: upstream throttles on `almost_full`.

---
 rtl/nx_accum_pkg.sv | 39 +++
 rtl/nx_accum_fifo.sv | 70 +++++++
 rtl/nx_accum_drain.sv | 111 +++++++++++
 tb/tb_nx_accum_drain.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_accum_pkg.sv
//------------------------------------------------------------------------------
// Module : nx_accum_pkg
// Brief  : Default widths, saturation helper and almost_full threshold for
//          the nx_accum_drain block.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nx_accum_pkg;

   localparam int c_size_in   = 30;
   localparam int c_size_acc  = 40;
   localparam int c_size_out  = 16;
   localparam int c_shift     = 0;
   localparam int c_depth     = 4;
   localparam int c_af_margin = 2;

   // Clamp a signed value into the signed range of a w-bit result.
   function automatic logic signed [63:0] nx_saturate(input logic signed [63:0] v,
                                                      input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

   function automatic int nx_af_threshold(input int depth, input int margin);
      return (depth > margin) ? (depth - margin) : 0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nx_accum_fifo.sv
//------------------------------------------------------------------------------
// Module : nx_accum_fifo
// Brief  : Synchronous power-of-two FIFO; head is read from the register array.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nx_accum_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [WIDTH-1:0]          data_i,
   input  logic                      pop_i,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic [WIDTH-1:0]          head_o
);

   localparam int            c_aw   = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_aw-1:0]  wr_q, rd_q;
   logic [c_aw:0]    cnt_q, cnt_d;
   logic             push_ok_w, pop_ok_w;

   assign full_o    = (cnt_q == c_full);
   assign empty_o   = (cnt_q == '0);
   assign count_o   = cnt_q;
   assign head_o    = mem_q[rd_q];
   assign pop_ok_w  = pop_i & ~empty_o;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok_w = push_i & (~full_o | pop_ok_w);

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok_w && !pop_ok_w) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_ok_w && pop_ok_w) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_ok_w) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok_w) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/nx_accum_drain.sv
//------------------------------------------------------------------------------
// Module : nx_accum_drain
// Brief  : Per-vector accumulate, shift/saturate and output FIFO with drop flag.
//          Define NX_ACCUM_ROUND_EN for round-half-up scaling instead of floor.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nx_accum_drain
   import nx_accum_pkg::*;
#(
   parameter int SIZE_IN   = c_size_in,
   parameter int SIZE_ACC  = c_size_acc,
   parameter int SIZE_OUT  = c_size_out,
   parameter int SHIFT     = c_shift,
   parameter int DEPTH     = c_depth,
   parameter int AF_MARGIN = c_af_margin
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_last,
   input  logic [SIZE_IN-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SIZE_OUT-1:0] out_data,
   output logic                almost_full,
   output logic                out_drop
);

   localparam int c_aw    = $clog2(DEPTH);
   localparam int c_af_th = nx_af_threshold(DEPTH, AF_MARGIN);

   logic signed [SIZE_ACC-1:0] acc_q, acc_d, prod_w;
   logic                       first_q, first_d;
   logic                       done_q, done_d;
   logic                       drop_q, drop_d;
   logic                       af_q, af_d;
   logic                       fifo_full_w, fifo_empty_w, pop_w;
   logic [c_aw:0]              count_w;
   logic signed [SIZE_ACC:0]   ext_w, rnd_w, shf_w;
   logic [SIZE_OUT-1:0]        res_w;

   assign prod_w      = SIZE_ACC'($signed(in_data));
   assign out_valid   = ~fifo_empty_w;
   assign pop_w       = ~fifo_empty_w & out_ready;
   assign almost_full = af_q;
   assign out_drop    = drop_q;

   // One guard bit so the rounding offset cannot wrap before saturation.
   assign ext_w = {acc_q[SIZE_ACC-1], acc_q};
`ifdef NX_ACCUM_ROUND_EN
   generate
      if (SHIFT > 0) begin : g_round
         assign rnd_w = ext_w + ((SIZE_ACC + 1)'(1) <<< (SHIFT - 1));
      end else begin : g_no_round
         assign rnd_w = ext_w;
      end
   endgenerate
`else
   assign rnd_w = ext_w;
`endif
   assign shf_w = rnd_w >>> SHIFT;
   assign res_w = SIZE_OUT'(nx_saturate(64'(shf_w), SIZE_OUT));

   always_comb begin
      acc_d   = acc_q;
      first_d = first_q;
      done_d  = in_valid & in_last;
      if (in_valid) begin
         acc_d   = first_q ? prod_w : (acc_q + prod_w);
         first_d = in_last;
      end
      drop_d = drop_q | (done_q & fifo_full_w & ~pop_w);
      af_d   = (32'(count_w) >= 32'(c_af_th));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         af_q    <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         first_q <= first_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
         af_q    <= af_d;
      end
   end

   nx_accum_fifo #(
      .WIDTH (SIZE_OUT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (done_q),
      .data_i  (res_w),
      .pop_i   (pop_w),
      .full_o  (fifo_full_w),
      .empty_o (fifo_empty_w),
      .count_o (count_w),
      .head_o  (out_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_nx_accum_drain.sv
//------------------------------------------------------------------------------
// Module : tb_nx_accum_drain
// Brief  : Two instances (SHIFT=0 and SHIFT=2) fed the same stream, checked
//          against directed tables and a queue-based reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nx_accum_drain;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [29:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        ov0, af0, dr0, ov2, af2, dr2;
   logic [15:0] od0, od2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nx_accum_drain #(.SHIFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .almost_full(af0), .out_drop(dr0)
   );

   nx_accum_drain #(.SHIFT(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .almost_full(af2), .out_drop(dr2)
   );

   // Reference model: queue of finished full-precision sums.
   longint mq[$];
   longint m_acc = 0;
   longint m_pend = 0;
   bit     m_first = 1'b1;
   bit     m_pend_v = 1'b0;
   bit     m_drop = 1'b0;
   bit     m_af = 1'b0;

   function automatic longint wrap40(input longint x);
      return (x <<< 24) >>> 24;
   endfunction

   function automatic longint scale(input longint s, input int sh);
      longint r;
      r = s;
      if (sh > 0) begin
`ifdef NX_ACCUM_ROUND_EN
         r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
`else
         r = s >>> sh;
`endif
      end
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit v, input bit l, input logic [29:0] d,
                             input bit r, input bit rs);
      int  cnt;
      bit  pop;
      if (rs) begin
         mq.delete();
         m_acc = 0; m_first = 1'b1; m_pend_v = 1'b0;
         m_drop = 1'b0; m_af = 1'b0;
         return;
      end
      cnt  = mq.size();
      m_af = (cnt >= 2);
      pop  = (cnt > 0) && r;
      if (pop) void'(mq.pop_front());
      if (m_pend_v) begin
         if (cnt < 4 || pop) mq.push_back(m_pend);
         else m_drop = 1'b1;
      end
      m_pend_v = 1'b0;
      if (v) begin
         m_acc = m_first ? longint'($signed(d)) : wrap40(m_acc + longint'($signed(d)));
         m_first = l;
         if (l) begin
            m_pend_v = 1'b1;
            m_pend   = m_acc;
         end
      end
   endtask

   task automatic check_model();
      chk("valid0", longint'(ov0), longint'(mq.size() > 0));
      chk("valid2", longint'(ov2), longint'(mq.size() > 0));
      chk("drop0", longint'(dr0), longint'(m_drop));
      chk("drop2", longint'(dr2), longint'(m_drop));
      chk("af0", longint'(af0), longint'(m_af));
      chk("af2", longint'(af2), longint'(m_af));
      if (mq.size() > 0) begin
         chk("data0", longint'($signed(od0)), scale(mq[0], 0));
         chk("data2", longint'($signed(od2)), scale(mq[0], 2));
      end
   endtask

   task automatic step(input bit v, input bit l, input logic [29:0] d, input bit r);
      in_valid  = v;
      in_last   = l;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      model_edge(v, l, d, r, rst);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   typedef struct {
      int n;
      int p[3];
      int e0;
      int e2t;
      int e2r;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int exp2;
      logic [29:0] rd;
      bit rl;

      tbl[0] = '{3, '{3, 5, -2},        6,      1,      2};
      tbl[1] = '{1, '{40000, 0, 0},     32767,  10000,  10000};
      tbl[2] = '{1, '{-40000, 0, 0},    -32768, -10000, -10000};
      tbl[3] = '{1, '{6, 0, 0},         6,      1,      2};
      tbl[4] = '{1, '{-6, 0, 0},        -6,     -2,     -1};
      tbl[5] = '{1, '{131071, 0, 0},    32767,  32767,  32767};
      tbl[6] = '{2, '{-131072, -3, 0},  -32768, -32768, -32768};
      tbl[7] = '{2, '{5, -5, 0},        0,      0,      0};

      do_reset();
      chk("rst_valid", longint'(ov0), 0);
      chk("rst_af", longint'(af0), 0);
      chk("rst_drop", longint'(dr0), 0);
      chk("rst_data0", longint'(od0), 0);
      chk("rst_data2", longint'(od2), 0);

      // Directed vectors: value and 2-cycle latency from the last beat.
      for (int i = 0; i < 8; i++) begin
`ifdef NX_ACCUM_ROUND_EN
         exp2 = tbl[i].e2r;
`else
         exp2 = tbl[i].e2t;
`endif
         for (int k = 0; k < tbl[i].n; k++) begin
            step(1'b1, (k == tbl[i].n - 1), 30'(tbl[i].p[k]), 1'b1);
         end
         chk("lat_early", longint'(ov0), 0);
         step(1'b0, 1'b0, '0, 1'b1);
         chk("lat_valid", longint'(ov0), 1);
         chk("vec_data0", longint'($signed(od0)), longint'(tbl[i].e0));
         chk("vec_data2", longint'($signed(od2)), longint'(exp2));
         step(1'b0, 1'b0, '0, 1'b1);
      end

      // Backpressure: five results into a 4-deep FIFO, the fifth is dropped.
      do_reset();
      for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 30'(k), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("bp_drop", longint'(dr0), 1);
      chk("bp_af", longint'(af0), 1);
      for (int k = 1; k <= 4; k++) begin
         chk("bp_valid", longint'(ov0), 1);
         chk("bp_order", longint'($signed(od0)), longint'(k));
         step(1'b0, 1'b0, '0, 1'b1);
      end
      chk("bp_empty", longint'(ov0), 0);

      // Full FIFO with a pop in the push cycle: no drop, count stays 4.
      do_reset();
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 30'(k), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 30'd9, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("fp_nodrop", longint'(dr0), 0);
      begin
         int exq[4] = '{2, 3, 4, 9};
         for (int k = 0; k < 4; k++) begin
            chk("fp_valid", longint'(ov0), 1);
            chk("fp_order", longint'($signed(od0)), longint'(exq[k]));
            step(1'b0, 1'b0, '0, 1'b1);
         end
      end
      chk("fp_empty", longint'(ov0), 0);

      // Reset in the middle of a vector discards the partial sum.
      step(1'b1, 1'b0, 30'd7, 1'b1);
      step(1'b1, 1'b0, 30'd9, 1'b1);
      rst = 1'b1;
      step(1'b0, 1'b0, '0, 1'b1);
      rst = 1'b0;
      step(1'b1, 1'b1, 30'd4, 1'b1);
      chk("rm_early", longint'(ov0), 0);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("rm_valid", longint'(ov0), 1);
      chk("rm_data", longint'($signed(od0)), 4);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("rm_empty", longint'(ov0), 0);
      chk("rm_drop", longint'(dr0), 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(1, 0) == 1) rd = 30'($signed($urandom_range(2000, 0)) - 1000);
         else rd = 30'($urandom);
         rl = ($urandom_range(2, 0) == 0);
         step(($urandom_range(3, 0) != 0), rl, rd, ($urandom_range(1, 0) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
